randexp: RTL and testbench
==========================

// Module: randexp
// PURPOSE
// - Inverse companion to the log-domain RNG: computes exp(-x) for a 16.16 fixed-point x >= 0.
// - Maps log-domain quantities (energy deltas, log-uniform draws) back to linear probabilities in [0,1).
// - Used by the MCMC acceptance path: range reduction to base 2, internal LUT, linear interpolation, shift.
// - 4-stage pipeline with valid/ready on both sides; sustains one result per clock.
// PARAMETERS
// - LUT_FILE   "exp2_lut.hex"  $readmemh init; 257 x 17-bit entries, T[i]=round(65536*2^(-i/256)), T[256]=0x08000
// - LOG2E      17'h17154       log2(e) as unsigned 1.16
// PORTS
// - clk        in   1   system clock, all state on rising edge
// - rst        in   1   asynchronous, active-low reset
// - in_valid   in   1   in_data valid
// - in_ready   out  1   block accepts in_data this cycle
// - in_data    in   32  x, unsigned 16.16; result is exp(-x)
// - out_valid  out  1   out_data valid
// - out_ready  in   1   downstream accepts out_data this cycle
// - out_data   out  16  exp(-x), unsigned 0.16; 1.0 saturates to 16'hFFFF
// BEHAVIOUR
// - Reset (rst=0, async): all stage valids=0, out_valid=0, out_data=16'h0000; in_ready=1 after release.
// - Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational, no in_valid dependency).
// - Input handshake: in_valid&&in_ready; output handshake: out_valid&&out_ready. No drop/duplicate/reorder.
// - When adv=1 every stage shifts; bubbles (valid=0) propagate as bubbles. adv=0 holds every stage.
// - Latency: accepted at edge N -> out_valid at edge N+4 (if no stall). Throughput 1/clk.
// - S1 range reduction: p = in_data*LOG2E (49b); y = p[47:16] (16.16);
//   k = y[31:16], f = y[15:0]; flag zero_res if p[48] or k >= 16.
// - S2 LUT read: a = f[15:8], r = f[7:0]; fetch T[a], T[a+1] (two read ports or 2-entry-wide ROM, registered).
// - S3 interp: m = T[a] - (((T[a]-T[a+1]) * r) >> 8); 17-bit unsigned, T monotone so no underflow.
// - S4 scale: q = m >> k (k in 0..15); out_data = (q > 16'hFFFF) ? 16'hFFFF : q[15:0]; zero_res -> 16'h0000.
// - Boundaries: x=0 -> 16'hFFFF; x >= ~11.09 (k>=16) -> 16'h0000; x=32'hFFFFFFFF -> 16'h0000.
// - out_data holds last value while out_valid=0 (no X); value only meaningful when out_valid=1.
// - Reset mid-stream: in-flight items discarded; no output for them after release.
// CONFIGURATION
// - RANDEXP_ROUND_EN defined: S4 rounds to nearest, q = (m + (k ? 1<<(k-1) : 0)) >> k, then saturate.
// - RANDEXP_ROUND_EN undefined: S4 truncates (plain right shift). Latency/handshake identical either way.
// TESTING
// - x=32'h00000000 -> out_data=16'hFFFF, 4 cycles after accept, out_ready=1.
// - x=32'h0000B172 (ln2) -> out_data within +/-2 LSB of 16'h8000; x=32'h00010000 (1.0) -> ~16'h5E2D +/-2.
// - x=32'h000B1721 (16*ln2) and x=32'hFFFFFFFF -> out_data=16'h0000.
// - Stream 64 random x with in_valid=1, out_ready low 10 cycles mid-stream -> in_ready low while full,
//   all 64 results in order, each within 2 LSB of a real-valued model; no loss/dup.
// - Random in_valid/out_ready toggling, 1000 items -> scoreboard match; full-rate when both held high.
// - Assert rst=0 with 3 items in flight -> out_valid=0, out_data=0 immediately; none emerge after release.
// - With RANDEXP_ROUND_EN: x=32'h0000B172 error <= 1 LSB; sweep error never worse than truncating build.

Source files
------------

// File: rtl/randexp.sv
// randexp: 4-stage valid/ready pipeline computing exp(-x) for unsigned 16.16 x, result unsigned 0.16.
// Optional macro RANDEXP_ROUND_EN: round-to-nearest in the final shift (default build truncates).
module randexp #(
    parameter logic [16:0] LOG2E = 17'h17154
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipe
    // advances together (adv); in_ready mirrors adv and never looks at in_valid.

    function automatic logic [63:0] isqrt(input logic [127:0] v);
        logic [63:0] res;
        logic [63:0] t;
        res = '0;
        for (int b = 63; b >= 0; b--) begin
            t = res | (64'd1 << b);
            if ({64'd0, t} * {64'd0, t} <= v) res = t;
        end
        return res;
    endfunction

    // T[i] = round(65536 * 2^(-i/256)), built from 2^(-2^-j) factors obtained by repeated
    // square roots of 0.5 in Q40, so no external table file is needed.
    function automatic logic [16:0] lut_val(input int i);
        logic [127:0] acc;
        logic [63:0]  c;
        logic [7:0]   b;
        b   = i[7:0];
        acc = 128'd1 << 40;
        c   = 64'd1 << 39;
        for (int j = 7; j >= 0; j--) begin
            c = isqrt({24'd0, c, 40'd0});
            if (b[j]) acc = (acc * {64'd0, c}) >> 40;
        end
        acc = (acc + (128'd1 << 23)) >> 24;
        if (i >= 256) acc = 128'h8000;
        return 17'(acc);
    endfunction

    logic [16:0] lut [0:256];
    for (genvar g = 0; g < 257; g++) begin : g_lut
        localparam logic [16:0] V = lut_val(g);
        assign lut[g] = V;
    end

    logic        adv;
    logic        v0_q, v1_q, v2_q, v3_q, out_valid_q;
    logic [31:0] x_q;
    logic        z1_q, z2_q, z3_q;
    logic [3:0]  k1_q, k2_q, k3_q;
    logic [15:0] f1_q;
    logic [7:0]  r2_q;
    logic [16:0] ta2_q, tb2_q, m3_q;
    logic [15:0] out_data_q, out_data_d;

    logic [32:0] y;
    logic        zero_d;
    logic [3:0]  k_d;
    logic [16:0] diff, corr, m_d;
    logic [17:0] q;
    logic [15:0] sat;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // y = (x * log2e) >> 16; bit 32 and integer bits >= 16 both mean the result underflows
    assign y      = 33'(({17'd0, x_q} * {32'd0, LOG2E}) >> 16);
    assign zero_d = y[32] | (|y[31:20]);
    assign k_d    = y[19:16];

    assign diff = ta2_q - tb2_q;
    assign corr = 17'(({8'd0, diff} * {17'd0, r2_q}) >> 8);
    assign m_d  = ta2_q - corr;

    always_comb begin
        q = {1'b0, m3_q};
`ifdef RANDEXP_ROUND_EN
        if (k3_q != 4'd0) q = q + (18'd1 << (k3_q - 4'd1));
`endif
        q   = q >> k3_q;
        sat = (q > 18'h0FFFF) ? 16'hFFFF : q[15:0];
    end

    // out_data only changes when a real item lands in the output register
    always_comb begin
        out_data_d = out_data_q;
        if (adv && v3_q) out_data_d = z3_q ? 16'h0000 : sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            z1_q        <= 1'b0;
            z2_q        <= 1'b0;
            z3_q        <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            f1_q        <= '0;
            r2_q        <= '0;
            ta2_q       <= '0;
            tb2_q       <= '0;
            m3_q        <= '0;
            out_data_q  <= '0;
        end else begin
            out_data_q <= out_data_d;
            if (adv) begin
                v0_q        <= in_valid;
                x_q         <= in_data;
                v1_q        <= v0_q;
                z1_q        <= zero_d;
                k1_q        <= k_d;
                f1_q        <= y[15:0];
                v2_q        <= v1_q;
                z2_q        <= z1_q;
                k2_q        <= k1_q;
                r2_q        <= f1_q[7:0];
                ta2_q       <= lut[{1'b0, f1_q[15:8]}];
                tb2_q       <= lut[{1'b0, f1_q[15:8]} + 9'd1];
                v3_q        <= v2_q;
                z3_q        <= z2_q;
                k3_q        <= k2_q;
                m3_q        <= m_d;
                out_valid_q <= v3_q;
            end
        end
    end

endmodule

// File: tb/tb_randexp.sv
// Bench for randexp: directed boundary points, stalled/random/full-rate streams, reset mid-stream.
module tb_randexp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

`ifdef RANDEXP_ROUND_EN
    localparam int LN2_TOL = 1;
`else
    localparam int LN2_TOL = 2;
`endif

    always #5 clk = ~clk;

    randexp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Real-valued exp(-x), scaled to 0.16 and clipped at 16'hFFFF
    function automatic int model(input logic [31:0] x);
        real v;
        v = $exp(-real'(x) / 65536.0) * 65536.0;
        if (v >= 65535.0) return 65535;
        return $rtoi(v + 0.5);
    endfunction

    function automatic logic [31:0] rand_x();
        if ($urandom_range(15) == 0) return $urandom();
        return $urandom_range(32'h000C0000);
    endfunction

    // One clock: drive, let combinational outputs settle, record handshakes, advance past the edge
    task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                        output logic fin, output logic fout, output logic [15:0] od,
                        output logic ir);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        od   = out_data;
        ir   = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_data got %h expected 0000", out_data);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] xs [6];
        int lo [6];
        int hi [6];
        int lat;
        xs = '{32'h00000000, 32'h0000B172, 32'h00010000, 32'h000B1721, 32'hFFFFFFFF, 32'h000C0000};
        lo = '{65535, 32768 - LN2_TOL, 24109 - 2, 0, 0, 0};
        hi = '{65535, 32768 + LN2_TOL, 24109 + 2, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_data   = xs[i];
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL directed_latency x=%h got %0d cycles expected 4", xs[i], lat);
            end
            checks++;
            if ($isunknown(out_data) || int'(out_data) < lo[i] || int'(out_data) > hi[i]) begin
                errors++;
                $display("FAIL directed_value x=%h got %h expected %0d..%0d", xs[i], out_data, lo[i], hi[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall_stream;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        int d;
        logic fin, fout, ir, rdy;
        logic [15:0] od, e;
        logic [31:0] x;
        exp_q.delete();
        x = rand_x();
        while ((sent < 64 || recv < 64) && cyc < 500) begin
            rdy = !(cyc >= 20 && cyc < 30);
            step(sent < 64, x, rdy, fin, fout, od, ir);
            if (cyc == 29) begin
                checks++;
                if (ir !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b expected 0", ir);
                end
            end
            if (fin) begin
                exp_q.push_back(16'(model(x)));
                sent++;
                x = rand_x();
            end
            if (fout) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra_output got %h expected none", od);
                end else begin
                    e = exp_q.pop_front();
                    d = int'(od) - int'(e);
                    if ($isunknown(od) || d < -2 || d > 2) begin
                        errors++;
                        $display("FAIL stall_item %0d got %h expected %h +/-2", recv, od, e);
                    end
                end
                recv++;
            end
            cyc++;
        end
        checks++;
        if (recv != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_count got %0d outputs expected 64 (pending %0d)", recv, exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        int holes = 0;
        int d;
        logic fin, fout, ir;
        logic [15:0] od, e;
        logic [31:0] x;
        exp_q.delete();
        x = rand_x();
        while ((sent < 32 || recv < 32) && cyc < 100) begin
            step(sent < 32, x, 1'b1, fin, fout, od, ir);
            if (sent < 32 && !fin) holes++;
            if (fin) begin
                exp_q.push_back(16'(model(x)));
                sent++;
                x = rand_x();
            end
            if (fout) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_output got %h expected none", od);
                end else begin
                    e = exp_q.pop_front();
                    d = int'(od) - int'(e);
                    if ($isunknown(od) || d < -2 || d > 2) begin
                        errors++;
                        $display("FAIL b2b_item %0d got %h expected %h +/-2", recv, od, e);
                    end
                end
                recv++;
            end
            cyc++;
        end
        checks++;
        if (holes != 0) begin
            errors++;
            $display("FAIL b2b_accept_holes got %0d expected 0", holes);
        end
        checks++;
        if (cyc != 37 || recv != 32) begin
            errors++;
            $display("FAIL b2b_cycles got %0d cycles/%0d outputs expected 37/32", cyc, recv);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_handshake;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        int d;
        logic pend = 1'b0;
        logic fin, fout, ir, rdy;
        logic [15:0] od, e;
        logic [31:0] x;
        exp_q.delete();
        x = rand_x();
        while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
            if (!pend && sent < 1000) pend = ($urandom_range(3) != 0);
            rdy = ($urandom_range(3) != 0);
            step(pend, x, rdy, fin, fout, od, ir);
            if (fin) begin
                exp_q.push_back(16'(model(x)));
                sent++;
                pend = 1'b0;
                x = rand_x();
            end
            if (fout) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_output got %h expected none", od);
                end else begin
                    e = exp_q.pop_front();
                    d = int'(od) - int'(e);
                    if ($isunknown(od) || d < -2 || d > 2) begin
                        errors++;
                        $display("FAIL rand_item %0d got %h expected %h +/-2", recv, od, e);
                    end
                end
                recv++;
            end
            cyc++;
        end
        checks++;
        if (recv != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count got %0d outputs expected 1000 (pending %0d)", recv, exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom_range(32'h00020000);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_fill got out_valid %b expected 1", out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_clear got valid %b data %h expected 0 0000", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_ghost got %0d outputs expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_stream();
        test_back_to_back();
        test_random_handshake();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
